booth_mult_seq: RTL and testbench
=================================

# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier with a start/busy/done handshake. It is the successor to the fixed 4-bit shift-add/subtract multiplier datapath and merges datapath and controller into one block. Key changes from that block:
- operand width is a parameter;
- signed or unsigned operation is selected per transaction;
- operands are latched on `start` rather than on reset;
- the result is held stable until the next transaction completes.

The block sits behind the lab's top-level switch/7-seg wrapper or any bus master.

## Interface
Parameters:
- `W`, default 8: operand width in bits, W ≥ 2.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `is_signed`  in  1  1 = two's-complement operands; 0 = unsigned. Latched with `start`.
- `a`  in  W  multiplicand. Latched with `start`.
- `b`  in  W  multiplier. Latched with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle.
- `product`  out  2W  result. Held until the next `done`.

## Operation
FSM states are IDLE, RUN and DONE.

- **IDLE → RUN** when `start` = 1:
  - Extend `a` and `b` to W+1 bits: sign-extend if `is_signed`, otherwise zero-extend.
  - M ← a_ext.
  - Accumulator register P (2W+3 bits) ← {(W+1) zeros, b_ext, 1'b0}. The LSB is the Booth q₋₁ bit.
  - Step counter ← W+1.
- **RUN**: one Booth step per cycle.
  - Examine {P[1], P[0]}. On 01, add M to P[2W+2:W+2]. On 10, subtract M from P[2W+2:W+2]. On 00 or 11, no change.
  - Then arithmetically shift the whole of P right by 1.
  - Decrement the counter. When the counter reaches 0 after a step, go to DONE.
- **DONE**: `product` ← P[2W:1], truncated to 2W bits. This is exact for both signed and unsigned W-bit operands. Assert `done`, then go to IDLE.
- Upper-half arithmetic is performed at W+2 bits so the add/subtract never overflows.
- `start` in RUN or DONE is ignored; it is not queued.
- Operand inputs are don't-care outside the IDLE start cycle.
- Reset, whether asynchronous or mid-transaction, forces IDLE and zeroes `busy`, `done`, `product`, P, M and the counter. An in-flight result is discarded.

## Timing
- Reset values: `busy` = 0, `done` = 0, `product` = 0.
- Let `start` be sampled in IDLE at edge T:
  - `busy` is high for cycles T+1 … T+W+1 (W+1 cycles).
  - `done` is high and `product` is updated in cycle T+W+2 only.
  - `busy` is 0 during DONE.
- Latency from start edge to `done` is W+2 cycles. Minimum start-to-start period is W+3 cycles, because the earliest new `start` is sampled in the IDLE cycle after DONE.
- `start` held continuously high produces back-to-back transactions every W+3 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `booth_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`);
  - the Booth recode constants (`BOOTH_NOP`, `BOOTH_ADD`, `BOOTH_SUB`).
- Sub-module `booth_step`, purely combinational and parametrised by W:
  - inputs are P and M;
  - it recodes, adds or subtracts, and arithmetic-shifts;
  - it outputs the next P.
- The top level holds the FSM, counter, registers and extension logic.

## Test plan
All scenarios use W = 8.
- Signed −3 × 5 (a = 0xFD, b = 0x05, `is_signed` = 1) → `product` = 0xFFF1. `done` exactly 10 cycles after the start edge; `busy` high for 9 cycles.
- Unsigned 255 × 255 (`is_signed` = 0) → 0xFE01. The same operands with `is_signed` = 1 (−1 × −1) → 0x0001.
- Signed corners:
  - −128 × −128 → 0x4000;
  - 127 × −128 → 0xC080;
  - 0 × 0xA5 → 0x0000.
- `start` held high, with `a`/`b` changing during RUN → result uses only the latched operands. The second transaction's `done` occurs 11 cycles after the first `done`.
- `rst` pulsed low mid-RUN → `busy`, `done` and `product` go to 0 immediately, with no `done` pulse. A following start of 7 × 6 (signed) → 0x002A.
- Randomised cross-check of 1000 transactions against a reference model, for both modes, with W = 4 and W = 16 as well.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: controller states and
// radix-2 recode operations.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP,
        BOOTH_ADD,
        BOOTH_SUB
    } booth_op_t;

    // Radix-2 recode of the pair {P[1], q-1}.
    function automatic booth_op_t booth_recode(input logic [1:0] pair);
        booth_op_t op;
        case (pair)
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/busy/done handshake bundle for booth_mult_seq; the bus master drives
// the request side, the multiplier drives status and result.
interface booth_mult_seq_if #(
    parameter int W = 8
);
    logic           start;
    logic           is_signed;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: recode {P[1],P[0]}, add/subtract M into the
// upper part of P, then arithmetic-shift the whole accumulator right by one.
module booth_step
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2*W+2:0] p,
    input  logic [W:0]     m,
    output logic [2*W+2:0] p_next
);
    logic [W+1:0] upper;
    logic [W+1:0] m_ext;
    logic [W+1:0] sum;
    booth_op_t    op;

    // Upper half is widened by one bit so add/subtract cannot overflow; that
    // extra bit then becomes the sign fill of the shift.
    always_comb begin
        upper  = {p[2*W+2], p[2*W+2:W+2]};
        m_ext  = {m[W], m};
        op     = booth_recode(p[1:0]);
        sum    = upper;
        case (op)
            BOOTH_ADD: sum = upper + m_ext;
            BOOTH_SUB: sum = upper - m_ext;
            default:   sum = upper;
        endcase
        p_next = {sum, p[W+1:1]};
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, W-bit signed/unsigned operands,
// W+1 Booth steps per transaction, result held until the next done.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    booth_mult_seq_if.slave  bus
);
    localparam int PW = 2*W + 3;
    localparam int CW = $clog2(W + 2);

    state_t         state_reg, state_next;
    logic [PW-1:0]  p_reg, p_next, p_step;
    logic [W:0]     m_reg, m_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [2*W-1:0] product_reg, product_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic [W:0]     a_ext, b_ext;

    // One extra bit lets unsigned operands run through the signed recoder.
    assign a_ext = {bus.is_signed & bus.a[W-1], bus.a};
    assign b_ext = {bus.is_signed & bus.b[W-1], bus.b};

    booth_step #(.W(W)) u_step (
        .p      (p_reg),
        .m      (m_reg),
        .p_next (p_step)
    );

    always_comb begin
        state_next   = state_reg;
        p_next       = p_reg;
        m_next       = m_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    m_next     = a_ext;
                    p_next     = {{(W+1){1'b0}}, b_ext, 1'b0};
                    cnt_next   = CW'(W + 1);
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                p_next   = p_step;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    // Capture on the final step so product is valid with done.
                    product_next = p_step[2*W:1];
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next == ST_RUN);
        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            p_reg       <= '0;
            m_reg       <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            p_reg       <= p_next;
            m_reg       <= m_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.product = product_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at W = 4, 8, 16: directed corners, handshake timing,
// reset abort and randomised products against a plain-arithmetic model.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    booth_mult_seq_if #(.W(4))  bus4 ();
    booth_mult_seq_if #(.W(8))  bus8 ();
    booth_mult_seq_if #(.W(16)) bus16 ();

    booth_mult_seq #(.W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    booth_mult_seq #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    booth_mult_seq #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Product of the two W-bit operands, read as signed or unsigned, kept to 2W bits.
    function automatic longint ref_prod(input int w, input bit sg, input longint a, input longint b);
        longint mask_w;
        longint av;
        longint bv;
        mask_w = (longint'(1) << w) - 1;
        av = a & mask_w;
        bv = b & mask_w;
        if (sg && av[w-1]) av = av - (longint'(1) << w);
        if (sg && bv[w-1]) bv = bv - (longint'(1) << w);
        return (av * bv) & ((longint'(1) << (2*w)) - 1);
    endfunction

    task automatic drive(input int w, input bit st, input bit sg, input longint a, input longint b);
        case (w)
            4: begin
                bus4.start = st; bus4.is_signed = sg; bus4.a = a[3:0]; bus4.b = b[3:0];
            end
            8: begin
                bus8.start = st; bus8.is_signed = sg; bus8.a = a[7:0]; bus8.b = b[7:0];
            end
            default: begin
                bus16.start = st; bus16.is_signed = sg; bus16.a = a[15:0]; bus16.b = b[15:0];
            end
        endcase
    endtask

    function automatic bit get_busy(input int w);
        case (w)
            4:       return bus4.busy;
            8:       return bus8.busy;
            default: return bus16.busy;
        endcase
    endfunction

    function automatic bit get_done(input int w);
        case (w)
            4:       return bus4.done;
            8:       return bus8.done;
            default: return bus16.done;
        endcase
    endfunction

    function automatic longint get_prod(input int w);
        case (w)
            4:       return longint'(bus4.product);
            8:       return longint'(bus8.product);
            default: return longint'(bus16.product);
        endcase
    endfunction

    // lat counts cycles after the start edge: 1 is the first cycle after it.
    task automatic txn(input int w, input bit sg, input longint a, input longint b,
                       output longint prod, output int lat, output int nbusy);
        prod  = 0;
        lat   = -1;
        nbusy = 0;
        @(negedge clk);
        drive(w, 1'b1, sg, a, b);
        @(posedge clk);
        for (int c = 1; c <= 2*w + 8; c++) begin
            @(negedge clk);
            if (c == 1) drive(w, 1'b0, sg, longint'($urandom), longint'($urandom));
            if (get_busy(w)) nbusy++;
            if (get_done(w)) begin
                lat  = c;
                prod = get_prod(w);
                break;
            end
        end
        $display("txn W=%0d signed=%0d a=%0h b=%0h -> product=%0h lat=%0d", w, sg, a, b, prod, lat);
    endtask

    task automatic directed8(input string tag, input bit sg, input longint a, input longint b,
                             input longint exp);
        longint prod;
        int     lat, nbusy;
        txn(8, sg, a, b, prod, lat, nbusy);
        check(tag, prod, exp);
        check({tag, "_lat"}, lat, 10);
    endtask

    initial begin
        longint prod, p1, p2;
        int     lat, nbusy, d1, d2, ndone;
        int     widths[3] = '{4, 8, 16};

        drive(4, 0, 0, 0, 0);
        drive(8, 0, 0, 0, 0);
        drive(16, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus8.busy, 0);
        check("rst_done", bus8.done, 0);
        check("rst_prod8", bus8.product, 0);
        check("rst_prod16", bus16.product, 0);
        rst = 1'b1;

        // -3 x 5 with full handshake timing and result hold.
        txn(8, 1'b1, 64'hFD, 64'h05, prod, lat, nbusy);
        check("m3x5", prod, 64'hFFF1);
        check("m3x5_lat", lat, 10);
        check("m3x5_busy", nbusy, 9);
        repeat (4) @(negedge clk);
        check("hold_prod", bus8.product, 64'hFFF1);
        check("hold_done", bus8.done, 0);

        directed8("u255x255", 1'b0, 64'hFF, 64'hFF, 64'hFE01);
        directed8("s_m1xm1",  1'b1, 64'hFF, 64'hFF, 64'h0001);
        directed8("s_m128sq", 1'b1, 64'h80, 64'h80, 64'h4000);
        directed8("s127xm128", 1'b1, 64'h7F, 64'h80, 64'hC080);
        directed8("zero_a5",  1'b1, 64'h00, 64'hA5, 64'h0000);

        // start held high; operands scrambled while busy, 5 x 6 presented at restart.
        d1 = -1;
        d2 = -1;
        p1 = 0;
        p2 = 0;
        @(negedge clk);
        drive(8, 1'b1, 1'b1, 3, 4);
        @(posedge clk);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (get_done(8)) begin
                if (d1 < 0) begin
                    d1 = c;
                    p1 = get_prod(8);
                    drive(8, 1'b1, 1'b1, 5, 6);
                end else begin
                    d2 = c;
                    p2 = get_prod(8);
                    break;
                end
            end else if (d1 < 0 || get_busy(8)) begin
                drive(8, 1'b1, 1'b1, longint'($urandom), longint'($urandom));
            end
        end
        drive(8, 1'b0, 1'b0, 0, 0);
        $display("txn W=8 held-start products=%0h,%0h done cycles=%0d,%0d", p1, p2, d1, d2);
        check("held_p1", p1, 64'h000C);
        check("held_d1", d1, 10);
        check("held_p2", p2, 64'h001E);
        check("held_gap", d2 - d1, 11);

        // Reset pulled mid-RUN discards the transaction.
        @(negedge clk);
        drive(8, 1'b1, 1'b1, 64'h12, 64'h34);
        @(posedge clk);
        @(negedge clk);
        drive(8, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", bus8.busy, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", bus8.busy, 0);
        check("abort_done", bus8.done, 0);
        check("abort_prod", bus8.product, 0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus8.done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        directed8("s7x6", 1'b1, 7, 6, 64'h002A);

        // Randomised cross-check at every width, both modes.
        foreach (widths[i]) begin
            for (int n = 0; n < 1000; n++) begin
                longint ra, rb;
                bit     sg;
                ra = longint'($urandom);
                rb = longint'($urandom);
                sg = 1'($urandom_range(0, 1));
                txn(widths[i], sg, ra, rb, prod, lat, nbusy);
                check($sformatf("rnd_w%0d_prod", widths[i]), prod, ref_prod(widths[i], sg, ra, rb));
                check($sformatf("rnd_w%0d_lat", widths[i]), lat, widths[i] + 2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
